// File: rtl/ioport_mtap.sv
// Controller-port serializer for NUM_PADS pads with a two-pad-per-group multitap walk and
// per-pad rumble commands decoded from the P6 line. Each rumble value expires after a timeout.
module ioport_mtap #(
  parameter int unsigned NUM_PADS       = 4,
  parameter int unsigned SHIFT_BITS     = 16,
  parameter logic        FILL_BIT       = 1'b0,
  parameter logic [7:0]  RUMBLE_TAG     = 8'h72,
  parameter logic [23:0] RUMBLE_TIMEOUT = 24'd2000000
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             MULTITAP,
  input  logic                             PORT_LATCH,
  input  logic                             PORT_CLK,
  input  logic                             PORT_P6,
  output logic [1:0]                       PORT_DO,
  input  logic [NUM_PADS*12-1:0]           JOYSTICK,
  output logic [NUM_PADS*16-1:0]           RUMBLE,
  output logic [$clog2(NUM_PADS/2):0]      GROUP
);

  localparam int unsigned NUM_GROUPS = NUM_PADS / 2;
  localparam int unsigned GW         = $clog2(NUM_GROUPS) + 1;
  localparam int unsigned CW         = $clog2(SHIFT_BITS + 1);

  logic                           latch_q, pclk_q, sel_q;
  logic                           sel, clk_rise, sel_rise, latch_fall, load, tag_hit;
  logic [GW-1:0]                  group_q, group_d;
  logic [SHIFT_BITS-1:0]          line0_q, line0_d, line1_q, line1_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [15:0]                    win_q, win_d;
  logic [NUM_PADS-1:0][15:0]      rumble_q, rumble_d;
  logic [NUM_PADS-1:0][23:0]      tmo_q, tmo_d;
  logic [11:0]                    joy0, joy1;

  // Pad word in shift order, left-aligned so the unused tail shifts out as pressed-free ones.
  function automatic logic [SHIFT_BITS-1:0] pad_word(input logic [11:0] j);
    logic [11:0] f;
    f = {j[5], j[7], j[10], j[11], j[3], j[2], j[1], j[0], j[4], j[6], j[8], j[9]};
    return SHIFT_BITS'(f) << (SHIFT_BITS - 12);
  endfunction

  assign sel        = MULTITAP & ~PORT_P6;
  assign clk_rise   = PORT_CLK & ~pclk_q;
  assign sel_rise   = sel & ~sel_q;
  assign latch_fall = ~PORT_LATCH & latch_q;
  assign load       = PORT_LATCH | sel_rise;
  assign tag_hit    = ~PORT_LATCH & (win_q[15:8] == RUMBLE_TAG);

  always_comb begin
    group_d = group_q;
    if (PORT_LATCH || !MULTITAP) begin
      group_d = '0;
    end else if (sel_rise) begin
      group_d = (group_q == GW'(NUM_GROUPS - 1)) ? '0 : group_q + GW'(1);
    end
  end

  always_comb begin
    joy0 = JOYSTICK[11:0];
    joy1 = JOYSTICK[23:12];
    for (int unsigned p = 0; p < NUM_GROUPS; p++) begin
      if (group_d == GW'(p)) begin
        joy0 = JOYSTICK[24*p +: 12];
        joy1 = JOYSTICK[24*p+12 +: 12];
      end
    end
  end

  // Once the counter saturates the registers already hold only fill bits, so shifting stops.
  always_comb begin
    line0_d = line0_q;
    line1_d = line1_q;
    cnt_d   = cnt_q;
    if (load) begin
      line0_d = ~pad_word(joy0);
      line1_d = ~pad_word(joy1);
      cnt_d   = '0;
    end else if (clk_rise && cnt_q < CW'(SHIFT_BITS)) begin
      line0_d = {line0_q[SHIFT_BITS-2:0], FILL_BIT};
      line1_d = {line1_q[SHIFT_BITS-2:0], FILL_BIT};
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_comb begin
    win_d = win_q;
    if (latch_fall || tag_hit) begin
      win_d = '0;
    end else if (clk_rise && !PORT_LATCH) begin
      win_d = {win_q[14:0], PORT_P6};
    end
  end

  // Expiry first, then a tag for the same pad overrides it.
  always_comb begin
    rumble_d = rumble_q;
    tmo_d    = tmo_q;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      if (tmo_q[p] != 24'd0) begin
        tmo_d[p] = tmo_q[p] - 24'd1;
        if (tmo_q[p] == 24'd1) rumble_d[p] = '0;
      end
    end
    for (int unsigned p = 0; p < NUM_GROUPS; p++) begin
      if (tag_hit && group_q == GW'(p)) begin
        rumble_d[2*p] = {win_q[7:4], win_q[7:4], win_q[3:0], win_q[3:0]};
        tmo_d[2*p]    = RUMBLE_TIMEOUT;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      latch_q  <= 1'b0;
      pclk_q   <= 1'b0;
      sel_q    <= 1'b0;
      group_q  <= '0;
      line0_q  <= '1;
      line1_q  <= '1;
      cnt_q    <= '0;
      win_q    <= '0;
      rumble_q <= '0;
      tmo_q    <= '0;
    end else begin
      latch_q  <= PORT_LATCH;
      pclk_q   <= PORT_CLK;
      sel_q    <= sel;
      group_q  <= group_d;
      line0_q  <= line0_d;
      line1_q  <= line1_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      rumble_q <= rumble_d;
      tmo_q    <= tmo_d;
    end
  end

  // With multitap, D1 low while latched is the adapter's presence signature.
  assign PORT_DO = {~MULTITAP | (line1_q[SHIFT_BITS-1] & ~PORT_LATCH), line0_q[SHIFT_BITS-1]};
  assign RUMBLE  = rumble_q;
  assign GROUP   = group_q;

endmodule

// File: tb/tb_ioport_mtap.sv
// Bench for ioport_mtap with 8 pads: directed and randomized frames checked against a
// table-driven model of the pad word, group walk and rumble timing.
module tb_ioport_mtap;

  localparam int   NP = 8;
  localparam int   SB = 16;
  localparam int   TO = 300;
  localparam logic FB = 1'b0;

  logic              CLK = 1'b0;
  logic              RESET, MULTITAP, PORT_LATCH, PORT_CLK, PORT_P6;
  logic [1:0]        PORT_DO;
  logic [NP*12-1:0]  JOYSTICK;
  logic [NP*16-1:0]  RUMBLE;
  logic [2:0]        GROUP;

  int n_asrt = 0;
  int fails  = 0;
  int cyc    = 0;
  int map_tbl [12] = '{5, 7, 10, 11, 3, 2, 1, 0, 4, 6, 8, 9};

  ioport_mtap #(
    .NUM_PADS      (NP),
    .SHIFT_BITS    (SB),
    .FILL_BIT      (FB),
    .RUMBLE_TAG    (8'h72),
    .RUMBLE_TIMEOUT(24'(TO))
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MULTITAP  (MULTITAP),
    .PORT_LATCH(PORT_LATCH),
    .PORT_CLK  (PORT_CLK),
    .PORT_P6   (PORT_P6),
    .PORT_DO   (PORT_DO),
    .JOYSTICK  (JOYSTICK),
    .RUMBLE    (RUMBLE),
    .GROUP     (GROUP)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial bit k of a pad as seen at DO: inverted button, then released padding, then fill.
  function automatic logic exp_bit(input int pad, input int k);
    if (k < 12) return ~JOYSTICK[12*pad + map_tbl[k]];
    if (k < SB) return 1'b1;
    return FB;
  endfunction

  task automatic pclk_pulse();
    PORT_CLK = 1'b1; tick(); tick();
    PORT_CLK = 1'b0; tick(); tick();
  endtask

  task automatic latch_pulse();
    PORT_LATCH = 1'b1; tick(); tick();
    PORT_LATCH = 1'b0; tick();
  endtask

  task automatic check_frame(input string tag, input int g, input logic mt, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      chk({tag, "_d0"}, 128'(PORT_DO[0]), 128'(exp_bit(2*g, k)));
      chk({tag, "_d1"}, 128'(PORT_DO[1]), 128'(mt ? exp_bit(2*g+1, k) : 1'b1));
      pclk_pulse();
    end
  endtask

  // Shifts v MSB first on P6; returns the cycle on which the tag is acted on.
  task automatic send_word(input logic [15:0] v, output int hit);
    hit = 0;
    for (int i = 15; i >= 0; i--) begin
      PORT_P6 = v[i]; tick();
      PORT_CLK = 1'b1; tick();
      hit = cyc + 1;
      tick();
      PORT_CLK = 1'b0; tick();
    end
    PORT_P6 = 1'b1;
  endtask

  initial begin
    int g, n, h1, h2;
    logic [15:0] d0_seq;
    RESET = 1'b1; MULTITAP = 1'b0; PORT_LATCH = 1'b0; PORT_CLK = 1'b0; PORT_P6 = 1'b1;
    JOYSTICK = '0;
    #2;
    chk("rst_do", 128'(PORT_DO), 128'(2'b11));
    chk("rst_group", 128'(GROUP), 128'(0));
    chk("rst_rumble", RUMBLE, 128'(0));
    tick(); tick();
    RESET = 1'b0;
    tick();

    // Single pad, A pressed.
    JOYSTICK[11:0] = 12'h010;
    latch_pulse();
    d0_seq = '0;
    for (int k = 0; k < 16; k++) begin
      d0_seq = {d0_seq[14:0], PORT_DO[0]};
      chk("a_d1", 128'(PORT_DO[1]), 128'(1));
      pclk_pulse();
    end
    chk("a_seq", 128'(d0_seq), 128'(16'hFF7F));
    chk("a_fill", 128'(PORT_DO[0]), 128'(FB));

    // Multitap presence and group 1 selection.
    MULTITAP = 1'b1;
    JOYSTICK = {$urandom, $urandom, $urandom};
    JOYSTICK[47:0] = {12'h008, 12'h004, 12'h002, 12'h001};
    PORT_LATCH = 1'b1; tick(); tick();
    chk("mt_sig_d1", 128'(PORT_DO[1]), 128'(0));
    chk("mt_lat_grp", 128'(GROUP), 128'(0));
    PORT_LATCH = 1'b0; tick();
    check_frame("mt_g0", 0, 1'b1, 9);
    PORT_P6 = 1'b0; tick();
    chk("mt_grp1", 128'(GROUP), 128'(1));
    PORT_P6 = 1'b1; tick();
    check_frame("mt_g1", 1, 1'b1, 8);

    // Group walk across all four groups, then a latch mid-frame.
    JOYSTICK = {$urandom, $urandom, $urandom};
    latch_pulse();
    g = 0;
    for (int i = 0; i < 6; i++) begin
      g = (g + 1) % (NP / 2);
      PORT_P6 = 1'b0; tick();
      chk("walk_grp", 128'(GROUP), 128'(g));
      chk("walk_d0", 128'(PORT_DO[0]), 128'(exp_bit(2*g, 0)));
      chk("walk_d1", 128'(PORT_DO[1]), 128'(exp_bit(2*g+1, 0)));
      PORT_P6 = 1'b1; tick();
    end
    pclk_pulse(); pclk_pulse(); pclk_pulse();
    PORT_LATCH = 1'b1; tick();
    chk("midlat_grp", 128'(GROUP), 128'(0));
    chk("midlat_d0", 128'(PORT_DO[0]), 128'(exp_bit(0, 0)));
    chk("midlat_d1", 128'(PORT_DO[1]), 128'(0));
    PORT_LATCH = 1'b0; tick();

    // Randomized frames with random multitap mode and group walks.
    for (int f = 0; f < 6; f++) begin
      JOYSTICK = {$urandom, $urandom, $urandom};
      MULTITAP = 1'($urandom_range(0, 1));
      latch_pulse();
      g = 0;
      if (MULTITAP) begin
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) begin
          PORT_P6 = 1'b0; tick();
          PORT_P6 = 1'b1; tick();
          g = (g + 1) % (NP / 2);
        end
      end
      chk("rnd_grp", 128'(GROUP), 128'(g));
      check_frame("rnd", g, MULTITAP, 18);
    end

    // Latch and clock rising together: load only, counter restarts.
    MULTITAP = 1'b0;
    JOYSTICK[11:0] = 12'h020;
    pclk_pulse();
    PORT_LATCH = 1'b1; PORT_CLK = 1'b1; tick();
    PORT_LATCH = 1'b0; PORT_CLK = 1'b0; tick();
    check_frame("latclk", 0, 1'b0, 18);

    // Rumble tag, timeout expiry, and a tag landing on the expiry cycle.
    latch_pulse();
    send_word(16'h72A5, h1);
    chk("rum_val", 128'(RUMBLE[15:0]), 128'(16'hAA55));
    chk("rum_others", 128'(RUMBLE[127:16]), 128'(0));
    while (cyc < h1 + TO - 1) tick();
    chk("rum_before_exp", 128'(RUMBLE[15:0]), 128'(16'hAA55));
    tick();
    chk("rum_expired", 128'(RUMBLE[15:0]), 128'(0));
    send_word(16'h72A5, h2);
    chk("rum_val2", 128'(RUMBLE[15:0]), 128'(16'hAA55));
    latch_pulse();
    for (int i = 15; i >= 1; i--) begin
      PORT_P6 = 1'(16'h723C >> i); tick();
      PORT_CLK = 1'b1; tick(); tick();
      PORT_CLK = 1'b0; tick();
    end
    PORT_P6 = 1'b0;
    while (cyc < h2 + TO - 2) tick();
    PORT_CLK = 1'b1; tick();
    chk("rum_pre_race", 128'(RUMBLE[15:0]), 128'(16'hAA55));
    tick();
    chk("rum_race", 128'(RUMBLE[15:0]), 128'(16'h33CC));
    PORT_CLK = 1'b0; PORT_P6 = 1'b1; tick();

    // Reset mid-frame, then a full frame.
    MULTITAP = 1'b1;
    JOYSTICK = {$urandom, $urandom, $urandom};
    latch_pulse();
    PORT_P6 = 1'b0; tick();
    PORT_P6 = 1'b1; tick();
    for (int i = 0; i < 5; i++) pclk_pulse();
    #1 RESET = 1'b1;
    #1;
    chk("arst_do", 128'(PORT_DO), 128'(2'b11));
    chk("arst_rumble", RUMBLE, 128'(0));
    chk("arst_group", 128'(GROUP), 128'(0));
    tick();
    RESET = 1'b0; tick();
    latch_pulse();
    check_frame("post_rst", 0, 1'b1, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, fails);
    $finish;
  end

endmodule
